// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle between the datapath, the load/store unit and memory.
// The slave modport is the load/store unit's view.
interface load_store_unit_if;
    logic        start;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;
    logic [31:0] mem_RD;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;

    modport slave (
        input  start, store, funct3, addr, wdata, mem_RD,
        output rdata, done, busy, err, mem_A, mem_WD, mem_WE
    );

    modport master (
        output start, store, funct3, addr, wdata, mem_RD,
        input  rdata, done, busy, err, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a big-endian, word-organised unified memory.
// Sub-word stores use a read-modify-write of the containing word.
module load_store_unit (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_err;
    logic        req_word_store;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept = (state_q == StIdle) && bus.start;

    always_comb begin
        req_illegal = 1'b1;
        unique case (bus.funct3)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = bus.store;
            default:                req_illegal = 1'b1;
        endcase
    end

    assign req_misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                            ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    assign req_err        = req_illegal || req_misaligned;
    assign req_word_store = bus.store && (bus.funct3 == 3'b010);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (req_err) begin
                        state_d = StDone;
                    end else if (req_word_store) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = store_q ? StWrite : StDone;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StDone);
        bus.mem_WE = (state_q == StWrite);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                store_q  <= bus.store;
                funct3_q <= bus.funct3;
                addr_q   <= bus.addr;
                wdata_q  <= bus.wdata;
                err_q    <= req_err;
            end
            if (state_q == StRead) begin
                word_q <= bus.mem_RD;
                if (!store_q) begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        rd_byte = bus.mem_RD[31:24];
        unique case (addr_q[1:0])
            2'd1:    rd_byte = bus.mem_RD[23:16];
            2'd2:    rd_byte = bus.mem_RD[15:8];
            2'd3:    rd_byte = bus.mem_RD[7:0];
            default: rd_byte = bus.mem_RD[31:24];
        endcase
        rd_half = addr_q[1] ? bus.mem_RD[15:0] : bus.mem_RD[31:16];

        unique case (funct3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'h0, rd_byte};
            3'b101:  load_val = {16'h0, rd_half};
            default: load_val = bus.mem_RD;
        endcase
    end

    always_comb begin
        merged = word_q;
        unique case (funct3_q[1:0])
            2'b00: begin
                unique case (addr_q[1:0])
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) begin
                    merged[15:0] = wdata_q[15:0];
                end else begin
                    merged[31:16] = wdata_q[15:0];
                end
            end
            default: merged = wdata_q;
        endcase
    end

    assign bus.mem_A  = {addr_q[31:2], 2'b00};
    assign bus.mem_WD = merged;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
endmodule
